water_level_sampler: RTL and testbench

Sensor front-end that produces the `water_level` stream consumed by `waterDrunk`. It samples a noisy raw 4-bit bottle-level sensor at a fixed divided rate. A new level is published only after it has been seen on a configurable number of consecutive samples. The block also flags sensor faults, so downstream consumption tracking only ever sees settled, valid levels.

---
 rtl/water_pkg.sv | 18 +
 rtl/water_level_sampler_median3.sv | 24 ++
 rtl/water_level_sampler.sv | 170 +++++++++++++++++
 tb/tb_water_level_sampler.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/water_pkg.sv
// rtl/water_pkg.sv - shared types and constants for the water level front-end
// Purpose: level type, sampler state encoding and level bounds shared by the
//          sampler top and its median filter helper.
package water_pkg;

    typedef logic [3:0] level_t;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        TRACK   = 2'd1,
        SETTLE  = 2'd2,
        FAULT   = 2'd3
    } sampler_state_t;

    localparam level_t LEVEL_EMPTY = 4'd0;
    localparam level_t LEVEL_FULL  = 4'd15;

endpackage

// File: rtl/water_level_sampler_median3.sv
// rtl/water_level_sampler_median3.sv - combinational median of three levels
// Purpose: picks the middle value of three level readings (spike rejection).
// Ports:
//   a, b, c : level_t inputs
//   median  : level_t middle value of a, b, c
module median3
    import water_pkg::*;
(
    input  level_t a,
    input  level_t b,
    input  level_t c,
    output level_t median
);

    always_comb begin
        median = c;
        if ((a >= b && a <= c) || (a <= b && a >= c)) begin
            median = a;
        end else if ((b >= a && b <= c) || (b <= a && b >= c)) begin
            median = b;
        end
    end

endmodule

// File: rtl/water_level_sampler.sv
// rtl/water_level_sampler.sv - debounced, fault-aware water level sensor sampler
// Purpose: samples sensor_raw once every SAMPLE_DIV cycles, publishes a level
//          only after STABLE_COUNT consecutive equal samples, and drops to a
//          fault state whenever the sensor reports unhealthy.
// Optional feature: define LEVEL_MEDIAN_EN to pass each tick's sample through
//          a median-of-three filter over the last three raw readings.
// Ports:
//   clk           : system clock, rising edge
//   reset         : synchronous active-high reset
//   sensor_raw    : raw 4-bit level reading (0 empty, 15 full)
//   sensor_ok     : sensor healthy, checked every cycle
//   water_level   : published settled level
//   level_valid   : water_level holds a settled reading
//   level_changed : one-cycle pulse on every publish
//   fault         : high while in FAULT
module water_level_sampler
    import water_pkg::*;
#(
    parameter int SAMPLE_DIV   = 4,
    parameter int STABLE_COUNT = 3
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sensor_raw,
    input  logic       sensor_ok,
    output logic [3:0] water_level,
    output logic       level_valid,
    output logic       level_changed,
    output logic       fault
);

    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int CNT_W = $clog2(STABLE_COUNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STABLE_COUNT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    sampler_state_t   state, state_n;
    logic [DIV_W-1:0] div;
    level_t           cand, cand_n;
    logic [CNT_W-1:0] count, count_n, count_inc;
    logic             tick;
    logic             publish;
    level_t           pub_val;
    level_t           sample;

    assign tick      = (div == DIV_LAST);
    assign count_inc = (count == CNT_FULL) ? count : count + CNT_ONE;

`ifdef LEVEL_MEDIAN_EN
    level_t hist1, hist2;

    median3 u_median3 (
        .a      (sensor_raw),
        .b      (hist1),
        .c      (hist2),
        .median (sample)
    );

    always_ff @(posedge clk) begin
        if (reset || !sensor_ok) begin
            hist1 <= LEVEL_EMPTY;
            hist2 <= LEVEL_EMPTY;
        end else if (tick) begin
            hist2 <= hist1;
            hist1 <= sensor_raw;
        end
    end
`else
    assign sample = sensor_raw;
`endif

    // Next-state logic assumes sensor_ok=1; the fault override lives in the
    // sequential block so that it beats any tick in the same cycle.
    always_comb begin
        state_n = state;
        cand_n  = cand;
        count_n = count;
        publish = 1'b0;
        pub_val = cand;
        case (state)
            ACQUIRE: begin
                if (tick) begin
                    if (sample == cand) begin
                        count_n = count_inc;
                    end else begin
                        cand_n  = sample;
                        count_n = CNT_ONE;
                    end
                    if (count_n == CNT_FULL) begin
                        publish = 1'b1;
                        pub_val = cand_n;
                        state_n = TRACK;
                    end
                end
            end
            TRACK: begin
                if (tick && sample != water_level) begin
                    cand_n  = sample;
                    count_n = CNT_ONE;
                    // A single-sample threshold publishes without visiting SETTLE.
                    if (count_n == CNT_FULL) begin
                        publish = 1'b1;
                        pub_val = sample;
                    end else begin
                        state_n = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (tick) begin
                    if (sample == cand) begin
                        count_n = count_inc;
                        if (count_n == CNT_FULL) begin
                            publish = 1'b1;
                            pub_val = cand;
                            state_n = TRACK;
                        end
                    end else if (sample == water_level) begin
                        count_n = '0;
                        state_n = TRACK;
                    end else begin
                        cand_n  = sample;
                        count_n = CNT_ONE;
                    end
                end
            end
            FAULT: begin
                state_n = ACQUIRE;
            end
            default: begin
                state_n = ACQUIRE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ACQUIRE;
            div           <= '0;
            cand          <= LEVEL_EMPTY;
            count         <= '0;
            water_level   <= LEVEL_EMPTY;
            level_valid   <= 1'b0;
            level_changed <= 1'b0;
            fault         <= 1'b0;
        end else if (!sensor_ok) begin
            state         <= FAULT;
            div           <= '0;
            cand          <= LEVEL_EMPTY;
            count         <= '0;
            level_valid   <= 1'b0;
            level_changed <= 1'b0;
            fault         <= 1'b1;
        end else begin
            state         <= state_n;
            div           <= tick ? '0 : div + DIV_W'(1);
            cand          <= cand_n;
            count         <= count_n;
            level_changed <= publish;
            fault         <= 1'b0;
            if (publish) begin
                water_level <= pub_val;
                level_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_water_level_sampler.sv
// tb/tb_water_level_sampler.sv - self-checking bench for water_level_sampler
module tb_water_level_sampler;

    localparam int D = 4;
    localparam int N = 3;

    logic       clk;
    logic       reset;
    logic [3:0] sensor_raw;
    logic       sensor_ok;
    logic [3:0] water_level;
    logic       level_valid;
    logic       level_changed;
    logic       fault;

    water_level_sampler #(
        .SAMPLE_DIV   (D),
        .STABLE_COUNT (N)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sensor_raw    (sensor_raw),
        .sensor_ok     (sensor_ok),
        .water_level   (water_level),
        .level_valid   (level_valid),
        .level_changed (level_changed),
        .fault         (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int pulses   = 0;

    // Reference: a run-length view of the tick samples. A level is published
    // when the current run of equal samples reaches N and either nothing is
    // valid yet or the run value differs from the published level.
    int m_div, m_run_val, m_run_len, m_level, m_h1, m_h2;
    bit m_valid, m_changed, m_fault;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int med3(input int a, input int b, input int c);
        int mx, mn;
        mx = (a > b) ? a : b;
        mx = (mx > c) ? mx : c;
        mn = (a < b) ? a : b;
        mn = (mn < c) ? mn : c;
        return a + b + c - mx - mn;
    endfunction

    task automatic model_clear_run();
        m_run_val = -1;
        m_run_len = 0;
        m_div     = 0;
        m_h1      = 0;
        m_h2      = 0;
    endtask

    task automatic model_update(input int raw, input bit ok, input bit rst);
        int s;
        m_changed = 0;
        if (rst) begin
            model_clear_run();
            m_level = 0;
            m_valid = 0;
            m_fault = 0;
        end else if (!ok) begin
            model_clear_run();
            m_valid = 0;
            m_fault = 1;
        end else if (m_fault) begin
            m_fault = 0;
            m_div   = (m_div + 1) % D;
        end else begin
            if (m_div == D - 1) begin
`ifdef LEVEL_MEDIAN_EN
                s    = med3(raw, m_h1, m_h2);
                m_h2 = m_h1;
                m_h1 = raw;
`else
                s = raw;
`endif
                if (s == m_run_val) m_run_len++;
                else begin
                    m_run_val = s;
                    m_run_len = 1;
                end
                if (m_run_len == N && (!m_valid || s != m_level)) begin
                    m_level   = s;
                    m_valid   = 1;
                    m_changed = 1;
                end
            end
            m_div = (m_div + 1) % D;
        end
    endtask

    task automatic step(input int raw, input bit ok, input bit rst);
        sensor_raw = 4'(raw);
        sensor_ok  = ok;
        reset      = rst;
        @(posedge clk);
        model_update(raw, ok, rst);
        #1;
        check("water_level", int'(water_level), m_level);
        check("level_valid", int'(level_valid), int'(m_valid));
        check("level_changed", int'(level_changed), int'(m_changed));
        check("fault", int'(fault), int'(m_fault));
        if (level_changed) pulses++;
    endtask

    task automatic hold_ticks(input int raw, input int nticks);
        for (int i = 0; i < nticks * D; i++) step(raw, 1'b1, 1'b0);
    endtask

    int cur, steps;

    initial begin
        sensor_raw = 4'd0;
        sensor_ok  = 1'b1;
        reset      = 1'b1;
        m_level = 0; m_valid = 0; m_changed = 0; m_fault = 0;
        model_clear_run();

        for (int i = 0; i < 3; i++) step(0, 1'b1, 1'b1);
        check("reset_level", int'(water_level), 0);
        check("reset_valid", int'(level_valid), 0);

        // Constant 9 from reset: ticks at 3, 7, 11, outputs rise after tick 11.
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step(9, 1'b1, 1'b0);
            if (i == 10) check("acq_valid_early", int'(level_valid), 0);
            if (i == 11) begin
                check("acq_pulse_c12", int'(level_changed), 1);
                check("acq_level_c12", int'(water_level), 9);
            end
        end
        check("acq_pulses", pulses, 1);

        // Interrupted candidate: no publish.
        pulses = 0;
        hold_ticks(9, 1); hold_ticks(9, 1); hold_ticks(5, 1);
        hold_ticks(9, 1); hold_ticks(9, 1);
        check("glitch_pulses", pulses, 0);
        check("glitch_level", int'(water_level), 9);

        pulses = 0;
        hold_ticks(6, 3);
        check("move6_pulses", pulses, 1);
        check("move6_level", int'(water_level), 6);

        pulses = 0;
        hold_ticks(4, 1); hold_ticks(3, 3);
        check("move3_pulses", pulses, 1);
        check("move3_level", int'(water_level), 3);

        // Fault mid-SETTLE, then full reacquire.
        hold_ticks(7, 1);
        step(7, 1'b0, 1'b0);
        step(7, 1'b0, 1'b0);
        check("fault_flag", int'(fault), 1);
        check("fault_valid", int'(level_valid), 0);
        check("fault_level_held", int'(water_level), 3);
        steps = 0;
        while (!level_valid && steps < 40) begin
            step(3, 1'b1, 1'b0);
            steps++;
        end
        check("reacquire_cycles", steps, 12);

        // One-tick spike must not publish.
        hold_ticks(8, 6);
        check("spike_pre_level", int'(water_level), 8);
        pulses = 0;
        hold_ticks(15, 1); hold_ticks(8, 3);
        check("spike_pulses", pulses, 0);
        check("spike_level", int'(water_level), 8);

        // Reset mid-SETTLE drops validity.
        hold_ticks(2, 1);
        step(2, 1'b1, 1'b1);
        check("reset_settle_valid", int'(level_valid), 0);
        check("reset_settle_level", int'(water_level), 0);

        // Randomized soak.
        cur = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                cur = ($urandom_range(0, 4) == 4) ? 15 : int'($urandom_range(0, 3));
            end
            step(cur, ($urandom_range(0, 99) >= 2), ($urandom_range(0, 499) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
